prpg_reseed_ctrl: RTL and testbench

Parametrised, reseedable pseudo-random pattern generator for the STUMPS BIST path. It supports internal-XOR (Galois) and external-XOR (Fibonacci) LFSR modes and takes seed/polynomial loads through a valid/ready handshake. A built-in shift/capture sequencer drives CHANNELS scan chains through a phase shifter. It sits between the BIST controller, which supplies seeds and start, and the scan-chain inputs of the CUT.

---
 rtl/prpg_pkg.sv | 41 ++++
 rtl/prpg_phase_shifter.sv | 25 ++
 rtl/prpg_reseed_ctrl.sv | 145 ++++++++++++++
 tb/tb_prpg_reseed_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prpg_pkg.sv
// Shared types, mode constants and pure helper functions for the reseedable PRPG.
package prpg_pkg;

  typedef enum logic [2:0] {IDLE, READY, SHIFT, CAPTURE, DONE} prpg_state_e;

  localparam logic GALOIS    = 1'b0;
  localparam logic FIBONACCI = 1'b1;

  // Widest LFSR the helpers handle; callers zero-extend and truncate around it.
  localparam int MAX_N = 64;

  typedef struct packed {
    int unsigned tap_a;
    int unsigned tap_b;
  } ps_taps_t;

  function automatic logic [MAX_N-1:0] lfsr_next(input logic [MAX_N-1:0] q,
                                                  input logic [MAX_N-1:0] p,
                                                  input logic m,
                                                  input int n);
    logic [MAX_N-1:0] r;
    logic fb;
    r  = '0;
    fb = (m == FIBONACCI) ? ^(q & p) : q[0];
    for (int i = 0; i < MAX_N - 1; i++) begin
      if (i < n - 1) r[i] = q[i + 1] ^ ((m == GALOIS) & q[0] & p[i]);
    end
    for (int i = 0; i < MAX_N; i++) begin
      if (i == n - 1) r[i] = fb;
    end
    return r;
  endfunction

  function automatic ps_taps_t phase_map(input int c, input int n, input int off);
    ps_taps_t t;
    t.tap_a = (2 * c) % n;
    t.tap_b = (2 * c + off) % n;
    return t;
  endfunction

endpackage

// File: rtl/prpg_phase_shifter.sv
// Combinational XOR phase shifter: each channel is the XOR of two LFSR taps.
module prpg_phase_shifter
  import prpg_pkg::*;
#(
  parameter int N         = 32,
  parameter int CHANNELS  = 8,
  parameter int PS_OFFSET = 3
) (
  input  logic [N-1:0]        q,
  output logic [CHANNELS-1:0] scan_out
);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      localparam ps_taps_t TAPS = phase_map(gi, N, PS_OFFSET);
      assign scan_out[gi] = q[TAPS.tap_a] ^ q[TAPS.tap_b];
    end
  endgenerate

  // With few channels some Q bits never reach a tap.
  logic unused_taps;
  assign unused_taps = ^q;

endmodule

// File: rtl/prpg_reseed_ctrl.sv
// Reseedable Galois/Fibonacci PRPG with seed handshake and shift/capture sequencer.
module prpg_reseed_ctrl
  import prpg_pkg::*;
#(
  parameter int PRPG_Size = 32,
  parameter int CHANNELS  = 8,
  parameter int PS_OFFSET = 3,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 internalRst,
  input  logic                 seed_valid,
  output logic                 seed_ready,
  input  logic [PRPG_Size-1:0] seed,
  input  logic [PRPG_Size-1:0] poly,
  input  logic                 mode,
  output logic                 seed_err,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     pattern_count,
  input  logic [CNT_W-1:0]     shift_len,
  input  logic                 scan_stall,
  output logic [CHANNELS-1:0]  scan_out,
  output logic                 scan_en,
  output logic                 capture,
  output logic                 busy,
  output logic                 done,
  output logic [PRPG_Size-1:0] lfsr_q
);

  prpg_state_e          state_reg, state_next;
  logic [PRPG_Size-1:0] q_reg, q_next;
  logic [PRPG_Size-1:0] p_reg, p_next;
  logic                 m_reg, m_next;
  logic [CNT_W-1:0]     shift_cnt_reg, shift_cnt_next;
  logic [CNT_W-1:0]     pat_cnt_reg, pat_cnt_next;
  logic [CNT_W-1:0]     pat_total_reg, pat_total_next;
  logic [CNT_W-1:0]     shift_total_reg, shift_total_next;
  logic                 seed_err_reg, seed_err_next;
  logic [PRPG_Size-1:0] q_step;
  logic [CNT_W-1:0]     shift_eff;
  logic                 load;

  assign q_step     = PRPG_Size'(lfsr_next(MAX_N'(q_reg), MAX_N'(p_reg), m_reg, PRPG_Size));
  assign shift_eff  = (shift_total_reg == '0) ? CNT_W'(1) : shift_total_reg;
  assign seed_ready = (state_reg == IDLE) || (state_reg == READY) || (state_reg == DONE);
  assign load       = seed_valid && seed_ready;

  always_comb begin
    state_next       = state_reg;
    q_next           = q_reg;
    p_next           = p_reg;
    m_next           = m_reg;
    shift_cnt_next   = shift_cnt_reg;
    pat_cnt_next     = pat_cnt_reg;
    pat_total_next   = pat_total_reg;
    shift_total_next = shift_total_reg;
    seed_err_next    = 1'b0;
    case (state_reg)
      IDLE, READY, DONE: begin
        if (state_reg == DONE) state_next = READY;
        // A load on the same edge as start takes precedence.
        if (load) begin
          if (seed == '0) begin
            seed_err_next = 1'b1;
          end else begin
            q_next     = seed;
            p_next     = poly;
            m_next     = mode;
            state_next = READY;
          end
        end else if (start && state_reg != IDLE) begin
          shift_cnt_next   = '0;
          pat_cnt_next     = '0;
          pat_total_next   = pattern_count;
          shift_total_next = shift_len;
          state_next       = (pattern_count == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_next = READY;
        end else if (!scan_stall) begin
          q_next = q_step;
          if (shift_cnt_reg + CNT_W'(1) >= shift_eff) begin
            shift_cnt_next = '0;
            state_next     = CAPTURE;
          end else begin
            shift_cnt_next = shift_cnt_reg + CNT_W'(1);
          end
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_next = READY;
        end else begin
          pat_cnt_next = pat_cnt_reg + CNT_W'(1);
          state_next   = (pat_cnt_reg + CNT_W'(1) == pat_total_reg) ? DONE : SHIFT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (internalRst) begin
      state_reg       <= IDLE;
      q_reg           <= '0;
      p_reg           <= '0;
      m_reg           <= 1'b0;
      shift_cnt_reg   <= '0;
      pat_cnt_reg     <= '0;
      pat_total_reg   <= '0;
      shift_total_reg <= '0;
      seed_err_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      q_reg           <= q_next;
      p_reg           <= p_next;
      m_reg           <= m_next;
      shift_cnt_reg   <= shift_cnt_next;
      pat_cnt_reg     <= pat_cnt_next;
      pat_total_reg   <= pat_total_next;
      shift_total_reg <= shift_total_next;
      seed_err_reg    <= seed_err_next;
    end
  end

  assign seed_err = seed_err_reg;
  assign scan_en  = (state_reg == SHIFT) && !scan_stall;
  assign capture  = (state_reg == CAPTURE);
  assign busy     = (state_reg == SHIFT) || (state_reg == CAPTURE);
  assign done     = (state_reg == DONE);
  assign lfsr_q   = q_reg;

  prpg_phase_shifter #(
    .N        (PRPG_Size),
    .CHANNELS (CHANNELS),
    .PS_OFFSET(PS_OFFSET)
  ) u_phase_shifter (
    .q       (q_reg),
    .scan_out(scan_out)
  );

endmodule

// File: tb/tb_prpg_reseed_ctrl.sv
// Self-checking bench: countdown-based reference model compared every cycle, plus literal pins.
module tb_prpg_reseed_ctrl;

  localparam int N   = 4;
  localparam int CH  = 4;
  localparam int OFF = 1;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          internalRst, seed_valid, mode, start, abort, scan_stall;
  logic [N-1:0]  seed, poly;
  logic [CW-1:0] pattern_count, shift_len;
  logic          seed_ready, seed_err, scan_en, capture, busy, done;
  logic [CH-1:0] scan_out;
  logic [N-1:0]  lfsr_q;

  int n_assert = 0;
  int n_fail   = 0;

  prpg_reseed_ctrl #(
    .PRPG_Size(N), .CHANNELS(CH), .PS_OFFSET(OFF), .CNT_W(CW)
  ) dut (
    .clk(clk), .internalRst(internalRst), .seed_valid(seed_valid), .seed_ready(seed_ready),
    .seed(seed), .poly(poly), .mode(mode), .seed_err(seed_err), .start(start), .abort(abort),
    .pattern_count(pattern_count), .shift_len(shift_len), .scan_stall(scan_stall),
    .scan_out(scan_out), .scan_en(scan_en), .capture(capture), .busy(busy), .done(done),
    .lfsr_q(lfsr_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference LFSR step written as whole-word shifts.
  function automatic logic [N-1:0] ref_step(input logic [N-1:0] q, input logic [N-1:0] p,
                                            input logic m);
    logic [N-1:0] top;
    top = {1'b1, {(N-1){1'b0}}};
    if (m) return (q >> 1) | ((($countones(q & p) % 2) == 1) ? top : '0);
    return (q >> 1) ^ (q[0] ? ((p & ~top) | top) : '0);
  endfunction

  function automatic logic [CH-1:0] ref_ps(input logic [N-1:0] q);
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = q[(2 * c) % N] ^ q[(2 * c + OFF) % N];
    return r;
  endfunction

  // Model: loaded flag, remaining shift/pattern countdowns, one-cycle capture/done flags.
  logic         model_ok = 1'b0;
  logic         m_loaded, m_shifting, m_capturing, m_done, m_err, m_m;
  logic [N-1:0] m_q, m_p;
  int           m_rem_shift, m_rem_pat, m_len;

  always @(posedge clk) begin : model
    int len;
    len = (shift_len == '0) ? 1 : int'(shift_len);
    m_err  <= 1'b0;
    m_done <= 1'b0;
    if (internalRst) begin
      model_ok    <= 1'b1;
      m_loaded    <= 1'b0;
      m_q         <= '0;
      m_p         <= '0;
      m_m         <= 1'b0;
      m_shifting  <= 1'b0;
      m_capturing <= 1'b0;
    end else if (m_shifting) begin
      if (abort) m_shifting <= 1'b0;
      else if (!scan_stall) begin
        m_q <= ref_step(m_q, m_p, m_m);
        if (m_rem_shift == 1) begin
          m_shifting  <= 1'b0;
          m_capturing <= 1'b1;
        end
        m_rem_shift <= m_rem_shift - 1;
      end
    end else if (m_capturing) begin
      m_capturing <= 1'b0;
      if (!abort) begin
        if (m_rem_pat == 1) m_done <= 1'b1;
        else begin
          m_shifting  <= 1'b1;
          m_rem_shift <= m_len;
        end
        m_rem_pat <= m_rem_pat - 1;
      end
    end else if (seed_valid) begin
      if (seed == '0) m_err <= 1'b1;
      else begin
        m_q      <= seed;
        m_p      <= poly;
        m_m      <= mode;
        m_loaded <= 1'b1;
      end
    end else if (start && m_loaded) begin
      m_len     <= len;
      m_rem_pat <= int'(pattern_count);
      if (pattern_count == '0) m_done <= 1'b1;
      else begin
        m_shifting  <= 1'b1;
        m_rem_shift <= len;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("lfsr_q", 64'(lfsr_q), 64'(m_q));
      chk("scan_out", 64'(scan_out), 64'(ref_ps(m_q)));
      chk("seed_ready", 64'(seed_ready), 64'(!(m_shifting || m_capturing)));
      chk("seed_err", 64'(seed_err), 64'(m_err));
      chk("scan_en", 64'(scan_en), 64'(m_shifting && !scan_stall));
      chk("capture", 64'(capture), 64'(m_capturing));
      chk("busy", 64'(busy), 64'(m_shifting || m_capturing));
      chk("done", 64'(done), 64'(m_done));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_n, cap_n, done_at;
    internalRst = 1'b1; seed_valid = 1'b0; seed = '0; poly = '0; mode = 1'b0;
    start = 1'b0; abort = 1'b0; scan_stall = 1'b0; pattern_count = '0; shift_len = '0;
    cyc(2);
    internalRst = 1'b0;
    chk("rst_seed_ready", 64'(seed_ready), 64'd1);
    chk("rst_lfsr_q", 64'(lfsr_q), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    $display("reset released");

    // start with no seed is ignored
    shift_len = 16'd2; pattern_count = 16'd1; start = 1'b1; cyc(1); start = 1'b0;
    chk("idle_start_ignored", 64'(busy), 64'd0);
    $display("start in IDLE: busy=%0b", busy);

    // Galois full period
    seed_valid = 1'b1; seed = 4'b0001; poly = 4'b0001; mode = 1'b0; cyc(1); seed_valid = 1'b0;
    chk("gal_load", 64'(lfsr_q), 64'h1);
    shift_len = 16'd15; pattern_count = 16'd1; start = 1'b1; cyc(1); start = 1'b0;
    chk("gal_entry_held", 64'(lfsr_q), 64'h1);
    cyc(1); chk("gal_s1", 64'(lfsr_q), 64'h9); chk("gal_ps1", 64'(scan_out), 64'hF);
    cyc(1); chk("gal_s2", 64'(lfsr_q), 64'hD); chk("gal_ps2", 64'(scan_out), 64'h5);
    cyc(1); chk("gal_s3", 64'(lfsr_q), 64'hF);
    cyc(12); chk("gal_cap16", 64'(capture), 64'd1); chk("gal_wrap", 64'(lfsr_q), 64'h1);
    cyc(1); chk("gal_done", 64'(done), 64'd1);
    cyc(1);
    $display("galois run: q=%b", lfsr_q);

    // Fibonacci
    seed_valid = 1'b1; seed = 4'b0001; poly = 4'b0011; mode = 1'b1; cyc(1); seed_valid = 1'b0;
    shift_len = 16'd4; pattern_count = 16'd1; start = 1'b1; cyc(1); start = 1'b0;
    cyc(1); chk("fib_s1", 64'(lfsr_q), 64'h8);
    cyc(1); chk("fib_s2", 64'(lfsr_q), 64'h4);
    cyc(1); chk("fib_s3", 64'(lfsr_q), 64'h2);
    cyc(1); chk("fib_s4", 64'(lfsr_q), 64'h9); chk("fib_cap", 64'(capture), 64'd1);
    cyc(2);
    $display("fibonacci run: q=%b", lfsr_q);

    // Continuation without reseed
    shift_len = 16'd1; pattern_count = 16'd1; start = 1'b1; cyc(1); start = 1'b0;
    cyc(1); chk("cont_q", 64'(lfsr_q), 64'hC);
    cyc(1); chk("cont_done", 64'(done), 64'd1);
    cyc(1);
    $display("continuation run: q=%b", lfsr_q);

    // Zero seed with simultaneous start: rejected, start ignored
    seed_valid = 1'b1; seed = '0; start = 1'b1; cyc(1); seed_valid = 1'b0; start = 1'b0;
    chk("zero_err", 64'(seed_err), 64'd1); chk("zero_q", 64'(lfsr_q), 64'hC);
    chk("zero_no_start", 64'(busy), 64'd0);
    cyc(1); chk("zero_err_pulse", 64'(seed_err), 64'd0);
    $display("zero seed: q=%b", lfsr_q);

    // shift_len 0 acts as 1
    shift_len = 16'd0; pattern_count = 16'd1; start = 1'b1; cyc(1); start = 1'b0;
    cyc(1); chk("len0_cap", 64'(capture), 64'd1); chk("len0_q", 64'(lfsr_q), 64'h6);
    cyc(1); chk("len0_done", 64'(done), 64'd1);
    cyc(1);
    $display("shift_len=0 run: q=%b", lfsr_q);

    // Run length with a 2-cycle stall in the second shift phase
    seed_valid = 1'b1; seed = 4'b0001; poly = 4'b0001; mode = 1'b0; cyc(1); seed_valid = 1'b0;
    shift_len = 16'd3; pattern_count = 16'd2; start = 1'b1; cyc(1); start = 1'b0;
    busy_n = 0; cap_n = 0; done_at = 0;
    for (int k = 1; k <= 30 && done_at == 0; k++) begin
      if (busy) busy_n++;
      if (capture) cap_n++;
      if (done) done_at = k;
      scan_stall = (k == 6 || k == 7);
      cyc(1);
    end
    scan_stall = 1'b0;
    chk("stall_busy_cycles", 64'(busy_n), 64'd10);
    chk("stall_captures", 64'(cap_n), 64'd2);
    chk("stall_done_cycle", 64'(done_at), 64'd11);
    chk("stall_q", 64'(lfsr_q), 64'hA);
    $display("stall run: busy=%0d captures=%0d done_at=%0d", busy_n, cap_n, done_at);

    // pattern_count 0: immediate done, no step
    pattern_count = 16'd0; start = 1'b1; cyc(1); start = 1'b0;
    chk("pc0_done", 64'(done), 64'd1); chk("pc0_q", 64'(lfsr_q), 64'hA);
    cyc(1);
    $display("pattern_count=0: q=%b", lfsr_q);

    // Abort during shift
    shift_len = 16'd5; pattern_count = 16'd1; start = 1'b1; cyc(1); start = 1'b0;
    cyc(1);
    abort = 1'b1; cyc(1); abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0); chk("abort_ready", 64'(seed_ready), 64'd1);
    chk("abort_q", 64'(lfsr_q), 64'h5);
    cyc(1); chk("abort_no_done", 64'(done), 64'd0);
    $display("abort: q=%b", lfsr_q);

    // Reset during capture
    shift_len = 16'd1; pattern_count = 16'd3; start = 1'b1; cyc(1); start = 1'b0;
    cyc(1); chk("rst_mid_cap", 64'(capture), 64'd1);
    internalRst = 1'b1; cyc(1); internalRst = 1'b0;
    chk("rst2_q", 64'(lfsr_q), 64'd0); chk("rst2_capture", 64'(capture), 64'd0);
    chk("rst2_busy", 64'(busy), 64'd0); chk("rst2_ready", 64'(seed_ready), 64'd1);
    chk("rst2_scan_out", 64'(scan_out), 64'd0);
    cyc(2);
    $display("reset mid-capture: q=%b busy=%0b", lfsr_q, busy);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
